// File: rtl/core_inst_seq.sv
// Instruction sequencer for one kij pass: weight load, activation load, execute, drain, psum write-out.
// Optional OUT-phase watchdog enabled by defining CORE_INST_SEQ_TIMEOUT_EN (adds timeout_err port).
module core_inst_seq #(
  parameter int          col     = 8,
  parameter int          row     = 8,
  parameter int          len_nij = 36,
  parameter logic [10:0] w_base  = 11'h400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode_select,
  input  logic [10:0] pmem_base,
  input  logic        ofifo_valid,
  output logic [34:0] inst,
  output logic        busy,
`ifdef CORE_INST_SEQ_TIMEOUT_EN
  output logic        timeout_err,
`endif
  output logic        done
);

  // state    | meaning
  // S_IDLE   | waiting for start, idle word
  // S_W_L0   | kernel words xmem -> L0 (col cycles)
  // S_W_LOAD | L0 -> PE weight load (col cycles)
  // S_X_L0   | activations xmem -> L0 (len_nij cycles)
  // S_EXEC   | L0 -> PE execute (len_nij cycles)
  // S_DRAIN  | execute with no new data (row+col cycles)
  // S_OUT    | ofifo -> pmem, one write per valid sample, len_nij writes
  // S_FIN    | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_W_L0, S_W_LOAD, S_X_L0, S_EXEC, S_DRAIN, S_OUT, S_FIN
  } state_t;

  localparam int CW = 16;
  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

  state_t        state, nstate;
  logic [CW-1:0] cnt, ncnt;
  logic [10:0]   pbase;
  logic [33:0]   inst_r;
  logic          nwr;
  logic [10:0]   out_idx;
  logic [10:0]   widx;

`ifdef CORE_INST_SEQ_TIMEOUT_EN
  logic [5:0] stall, nstall;
  logic       tmo_hit;
  logic       err_r;
`endif

  function automatic logic [33:0] word_of(input state_t s, input logic [10:0] idx,
                                          input logic [10:0] pb, input logic wr);
    logic [33:0] w;
    w = IDLE_WORD;
    case (s)
      S_W_L0: begin
        w[19]   = 1'b0;
        w[2]    = 1'b1;
        w[17:7] = w_base + idx;
      end
      S_W_LOAD: begin
        w[3] = 1'b1;
        w[0] = 1'b1;
      end
      S_X_L0: begin
        w[19]   = 1'b0;
        w[2]    = 1'b1;
        w[17:7] = idx;
      end
      S_EXEC: begin
        w[3] = 1'b1;
        w[1] = 1'b1;
      end
      S_DRAIN: w[1] = 1'b1;
      S_OUT: begin
        if (wr) begin
          w[6]     = 1'b1;
          w[32]    = 1'b0;
          w[31]    = 1'b0;
          w[30:20] = pb + idx;  // 11-bit sum, wraps at 2048
        end
      end
      default: w = IDLE_WORD;
    endcase
    return w;
  endfunction

  always_comb begin
    nstate  = state;
    ncnt    = cnt + CW'(1);
    nwr     = 1'b0;
    out_idx = '0;
`ifdef CORE_INST_SEQ_TIMEOUT_EN
    nstall  = '0;
    tmo_hit = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        ncnt = '0;
        if (start) nstate = S_W_L0;
      end
      S_W_L0:
        if (cnt == CW'(col - 1)) begin
          nstate = S_W_LOAD;
          ncnt   = '0;
        end
      S_W_LOAD:
        if (cnt == CW'(col - 1)) begin
          nstate = S_X_L0;
          ncnt   = '0;
        end
      S_X_L0:
        if (cnt == CW'(len_nij - 1)) begin
          nstate = S_EXEC;
          ncnt   = '0;
        end
      S_EXEC:
        if (cnt == CW'(len_nij - 1)) begin
          nstate = S_DRAIN;
          ncnt   = '0;
        end
      S_DRAIN:
        if (cnt == CW'(row + col - 1)) begin
          // OUT starts from zero writes; a valid sample here issues write 0 right away
          nstate = S_OUT;
          ncnt   = '0;
          if (ofifo_valid) begin
            nwr  = 1'b1;
            ncnt = CW'(1);
          end
        end
      S_OUT: begin
        // cnt counts writes already issued; exit once all len_nij are out
        if (cnt == CW'(len_nij)) begin
          nstate = S_FIN;
          ncnt   = '0;
        end else if (ofifo_valid) begin
          nwr     = 1'b1;
          out_idx = cnt[10:0];
        end else begin
          ncnt = cnt;
`ifdef CORE_INST_SEQ_TIMEOUT_EN
          if (stall == 6'd63) begin
            tmo_hit = 1'b1;
            nstate  = S_IDLE;
            ncnt    = '0;
          end else begin
            nstall = stall + 6'd1;
          end
`endif
        end
      end
      S_FIN: begin
        nstate = S_IDLE;
        ncnt   = '0;
      end
      default: begin
        nstate = S_IDLE;
        ncnt   = '0;
      end
    endcase
    widx = (nstate == S_OUT) ? out_idx : ncnt[10:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      pbase  <= '0;
      inst_r <= IDLE_WORD;
`ifdef CORE_INST_SEQ_TIMEOUT_EN
      stall  <= '0;
      err_r  <= 1'b0;
`endif
    end else begin
      state  <= nstate;
      cnt    <= ncnt;
      inst_r <= word_of(nstate, widx, pbase, nwr);
      if (state == S_IDLE && start) pbase <= pmem_base;
`ifdef CORE_INST_SEQ_TIMEOUT_EN
      stall <= nstall;
      if (tmo_hit) err_r <= 1'b1;
`endif
    end
  end

  assign inst = {mode_select, inst_r};
  assign busy = (state != S_IDLE);
  assign done = (state == S_FIN);
`ifdef CORE_INST_SEQ_TIMEOUT_EN
  assign timeout_err = err_r;
`endif

endmodule

// File: doc/core_inst_seq.md
CORE_INST_SEQ -- requirements
Module: core_inst_seq

Interface
REQ-001 SHALL have parameter col, default 8, meaning PE columns and weight words per pass.
REQ-002 SHALL have parameter row, default 8, meaning PE rows, used for drain length.
REQ-003 SHALL have parameter len_nij, default 36, meaning activation words per pass.
REQ-004 SHALL have parameter w_base, default 11'h400, meaning xmem address of the first kernel word.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port: clk  input  1  rising-edge clock.
REQ-007 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port: start  input  1  request one kij pass; sampled only in IDLE.
REQ-009 SHALL have port: mode_select  input  1  copied combinationally to inst[34].
REQ-010 SHALL have port: pmem_base  input  11  first psum address of the pass; captured on accepted start.
REQ-011 SHALL have port: ofifo_valid  input  1  core output FIFO has a row available.
REQ-012 SHALL have port: inst  output  35  core instruction bus.
- Bit fields: [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
REQ-013 SHALL have port: busy  output  1  high in every non-IDLE state.
REQ-014 SHALL have port: done  output  1  one-cycle pulse at end of pass.

Function
REQ-015 SHALL register inst[33:0]; inst[33:0] SHALL reflect the current state and counter value.
REQ-016 SHALL define the idle word: CEN_pmem=1, WEN_pmem=1, CEN_xmem=1, WEN_xmem=1; all other inst[33:0] bits 0.
REQ-017 SHALL implement states IDLE->W_L0->W_LOAD->X_L0->EXEC->DRAIN->OUT->FIN->IDLE, with one shared counter cnt that is cleared on every transition.
REQ-018 IDLE SHALL drive the idle word; start=1 SHALL move to W_L0, and the first W_L0 word SHALL appear the cycle after start is sampled.
REQ-019 W_L0, for col cycles, SHALL drive CEN_xmem=0, WEN_xmem=1, l0_wr=1, A_xmem=w_base+cnt.
REQ-020 W_LOAD, for col cycles, SHALL drive l0_rd=1, load=1, xmem idle.
REQ-021 X_L0, for len_nij cycles, SHALL drive CEN_xmem=0, WEN_xmem=1, l0_wr=1, A_xmem=cnt.
REQ-022 EXEC, for len_nij cycles, SHALL drive l0_rd=1, execute=1.
REQ-023 DRAIN, for row+col cycles, SHALL drive execute=1 with l0_rd=0.
REQ-024 OUT SHALL drive ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=pbase+cnt only in cycles where ofifo_valid=1; other cycles drive the idle word. cnt SHALL advance only on those write cycles.
REQ-025 OUT SHALL exit after len_nij writes.
REQ-026 A_pmem SHALL wrap modulo 2048 (11-bit addition, carry discarded).
REQ-027 FIN SHALL last one cycle, with done=1 and the idle word.
REQ-028 start while busy=1 SHALL be ignored and not queued; start in the FIN cycle SHALL be ignored.
REQ-029 acc, ififo_wr, ififo_rd SHALL be 0 in every state.

Reset
REQ-030 reset=1 at any clock edge SHALL force IDLE, cnt=0, pbase=0, inst[33:0]=idle word, busy=0, done=0 on the next cycle, including mid-pass.
REQ-031 A pass aborted by reset SHALL NOT produce done.

Configuration
REQ-032 SHALL support macro CORE_INST_SEQ_TIMEOUT_EN.
- Defined: adds output port timeout_err (1 bit, sticky, cleared only by reset). If OUT sees ofifo_valid=0 for 64 consecutive cycles, the block sets timeout_err, returns to IDLE with the idle word and no done.
- Undefined: no port; OUT waits indefinitely.

Verification
REQ-033 reset, then start=1 for one cycle with pmem_base=0 and ofifo_valid=1 throughout -> busy=1 for exactly 2*8+2*36+16+36+1 = 141 cycles; done pulses once; 36 pmem writes to addresses 0..35.
REQ-034 W_L0 observed -> A_xmem = 0x400..0x407, l0_wr=1, WEN_xmem=1 for 8 consecutive cycles, then load=1 for 8 cycles.
REQ-035 In OUT, hold ofifo_valid=0 for 5 cycles after the 10th write -> no ofifo_rd, CEN_pmem=1 for those 5 cycles; the next write goes to A_pmem = base+10.
REQ-036 pmem_base=2040 -> writes go to 2040..2047, then 0..27.
REQ-037 reset asserted in EXEC; start pulsed again during DRAIN of a second pass -> inst is the idle word the next cycle with no done; the second start is ignored and exactly one done occurs.
REQ-038 With CORE_INST_SEQ_TIMEOUT_EN defined, ofifo_valid=0 throughout OUT -> timeout_err=1 after 64 cycles, busy=0, done never asserted.
